// File: rtl/wb_register_file_pkg.sv
// Processor-wide constants shared by the write-back stage and the control unit.
package wb_register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int REG_ZERO = 0;

  // memToReg encodings; the control unit drives these same values
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_register_file_reg_read_port.sv
// One combinational register read port: zero register first, then
// bypass of the in-flight write, then the stored value.
module reg_read_port
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W  = wb_register_file_pkg::DATA_W,
  parameter int ADDR_W  = wb_register_file_pkg::ADDR_W,
  parameter int R0_ZERO = 0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  localparam logic R0_EN = (R0_ZERO != 0);

  always_comb begin
    data = stored;
    if (R0_EN && (addr == ADDR_W'(REG_ZERO))) begin
      data = '0;
    end else if (wr_en && (addr == wr_addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, serves two bypassed read ports and republishes the write for forwarding.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W  = wb_register_file_pkg::DATA_W,
  parameter int ADDR_W  = wb_register_file_pkg::ADDR_W,
  parameter int R0_ZERO = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] DataOutDataMemory,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              memToReg,
  input  logic [ADDR_W-1:0] registerFileWrite,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  output logic [DATA_W-1:0] writeBackData,
  output logic              fwdValid,
  output logic [ADDR_W-1:0] fwdAddr,
  output logic [DATA_W-1:0] fwdData
);

  localparam int   DEPTH = 2 ** ADDR_W;
  localparam logic R0_EN = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  always_comb begin
    writeBackData = ALUResult;
    case (memToReg)
      WB_SEL_ALU: writeBackData = ALUResult;
      WB_SEL_MEM: writeBackData = DataOutDataMemory;
      default:    writeBackData = ALUResult;
    endcase
  end

  // A write aimed at a hardwired-zero r0 is treated as if regWrite were low
  assign commit = regWrite && !(R0_EN && (registerFileWrite == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[registerFileWrite] <= writeBackData;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwdValid <= 1'b0;
      fwdAddr  <= '0;
      fwdData  <= '0;
    end else begin
      fwdValid <= commit;
      fwdAddr  <= registerFileWrite;
      fwdData  <= writeBackData;
    end
  end

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_port_a (
    .addr    (readAddrA),
    .stored  (regs[readAddrA]),
    .wr_en   (regWrite),
    .wr_addr (registerFileWrite),
    .wr_data (writeBackData),
    .data    (readDataA)
  );

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_port_b (
    .addr    (readAddrB),
    .stored  (regs[readAddrB]),
    .wr_en   (regWrite),
    .wr_addr (registerFileWrite),
    .wr_data (writeBackData),
    .data    (readDataB)
  );

endmodule
